param_stall_pipe: RTL

- Parametrised successor to the fixed five-stage stalling CPU datapath.
- Generic DEPTH-stage, DATA_W-wide pipeline with per-stage valid bits, a configurable stall point, bubble insertion, front-end flush and a stall watchdog that forces progress.
- Sits between the instruction source and the write-back sink; used as the datapath skeleton for information-flow (taint source to sink) checks.
- Bubbles and flushed stages carry zero data, so no stale value leaks downstream.

---
 rtl/stall_pipe_pkg.sv | 21 ++
 rtl/pipe_stage.sv | 49 ++++
 rtl/param_stall_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/stall_pipe_pkg.sv
// Shared types and helpers for the parametrised stalling pipeline.
package stall_pipe_pkg;

  // Default word width used by the reference stage type below.
  localparam int DEFAULT_DATA_W = 32;

  // One pipeline slot: a valid bit plus its data word.
  typedef struct packed {
    logic                      v;
    logic [DEFAULT_DATA_W-1:0] d;
  } stage_t;

  // An empty slot. Invalid slots always carry zero data.
  localparam stage_t BUBBLE = '{v: 1'b0, d: '0};

  // Width of a counter that must be able to hold values 0..max_stall.
  function automatic int calc_cw(input int max_stall);
    return (max_stall < 1) ? 1 : $clog2(max_stall + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Single pipeline register stage: valid bit plus data word.
// Priority of the control inputs is clear > hold > bubble > load.
module pipe_stage
  import stall_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic              i_prev_v,
  input  logic [DATA_W-1:0] i_prev_d,
  output logic              o_v,
  output logic [DATA_W-1:0] o_d
);

  logic              r_v;
  logic [DATA_W-1:0] r_d;

  // Stage register: squash, keep, insert an empty slot, or take the upstream slot.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data word is reset along with the valid bit so that an empty
    // stage never exposes a stale value, even straight out of reset.
    if (!rst_n) begin
      // NOTE: all register updates use <= so every stage samples its
      // neighbour's pre-edge value and the chain shifts by exactly one slot.
      r_v <= 1'b0;
      r_d <= '0;
    end else if (i_clear) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (i_hold) begin
      r_v <= r_v;
      r_d <= r_d;
    end else if (i_bubble) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else begin
      r_v <= i_prev_v;
      r_d <= i_prev_d;
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;

endmodule

// File: rtl/param_stall_pipe.sv
// DEPTH-stage stalling datapath skeleton with hold region 0..STALL_STAGE,
// bubble insertion above the hold region, front-end flush and a stall
// watchdog that forces the pipe to advance after MAX_STALL held cycles.
module param_stall_pipe
  import stall_pipe_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int DEPTH       = 4,
  parameter  int STALL_STAGE = 1,
  parameter  int MAX_STALL   = 15,
  localparam int CW          = calc_cw(MAX_STALL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              stall_req,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     stall_cnt,
  output logic              stall_overflow
);

  // Elaboration-time guards on the legal parameter ranges.
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_stall_pipe: DEPTH must be 2 or more");
  end
  if ((STALL_STAGE < 0) || (STALL_STAGE > DEPTH - 2)) begin : g_bad_stall_stage
    $error("param_stall_pipe: STALL_STAGE must lie in 0..DEPTH-2");
  end
  if (MAX_STALL < 1) begin : g_bad_max_stall
    $error("param_stall_pipe: MAX_STALL must be 1 or more");
  end

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STALL);

  logic              w_force;
  logic              w_eff_stall;
  logic [DATA_W-1:0] w_in_d;
  logic              w_v [DEPTH];
  logic [DATA_W-1:0] w_d [DEPTH];
  logic [CW-1:0]     r_stall_cnt;
  logic              r_overflow;

  // The watchdog overrides a stall request once the limit has been honoured;
  // a flush also overrides it, since the held words are being discarded.
  assign w_force     = stall_req && (r_stall_cnt == MAX_CNT);
  assign w_eff_stall = stall_req && !flush && !w_force;

  // Invalid input words enter as zero so no stale data rides an empty slot.
  assign w_in_d   = in_valid ? in_data : '0;
  assign in_ready = !w_eff_stall;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    localparam bit IN_HOLD = (i <= STALL_STAGE);
    localparam bit IS_EDGE = (i == STALL_STAGE + 1);

    logic              w_prev_v;
    logic [DATA_W-1:0] w_prev_d;

    if (i == 0) begin : g_head
      assign w_prev_v = in_valid;
      assign w_prev_d = w_in_d;
    end else begin : g_body
      assign w_prev_v = w_v[i-1];
      assign w_prev_d = w_d[i-1];
    end

    // The stage just above the hold region takes the word leaving it on a
    // flush (it is not cleared) and receives a bubble while the region holds.
    pipe_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (flush && IN_HOLD),
      .i_hold   (w_eff_stall && IN_HOLD),
      .i_bubble (w_eff_stall && IS_EDGE),
      .i_prev_v (w_prev_v),
      .i_prev_d (w_prev_d),
      .o_v      (w_v[i]),
      .o_d      (w_d[i])
    );
  end

  // Count consecutive honoured stalls; any cycle that advances the hold region
  // restarts the count, and a forced release raises a one-cycle overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_stall_cnt <= w_eff_stall ? (r_stall_cnt + CW'(1)) : '0;
      r_overflow  <= w_force && !flush;
    end
  end

  assign out_valid      = w_v[DEPTH-1];
  assign out_data       = w_d[DEPTH-1];
  assign stall_cnt      = r_stall_cnt;
  assign stall_overflow = r_overflow;

endmodule
